// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - Decode-side inputs and staged control outputs of pipe_ctrl.
// The fwd_*_e selects exist only when CTRL_FORWARD_EN is defined.
interface pipe_ctrl_if #(
  parameter int RF_ADDR_W = 5
);
  logic [31:0]          instr_d;
  logic                 valid_d;
  logic                 br_taken_e;
  logic [3:0]           aluop_e;
  logic                 sel_a_e;
  logic                 sel_b_e;
  logic [2:0]           br_type_e;
  logic                 jump_e;
  logic                 rd_en_m;
  logic                 wr_en_m;
  logic [2:0]           mem_mode_m;
  logic [2:0]           csr_op_m;
  logic                 csr_en_m;
  logic                 rf_en_w;
  logic [1:0]           wb_sel_w;
  logic [RF_ADDR_W-1:0] rd_w;
  logic                 stall_f;
  logic                 stall_d;
  logic                 flush_d;
  logic                 flush_e;
  logic                 illegal_d;
`ifdef CTRL_FORWARD_EN
  logic [1:0]           fwd_a_e;
  logic [1:0]           fwd_b_e;
`endif

  modport master (
    output instr_d, valid_d, br_taken_e,
    input  aluop_e, sel_a_e, sel_b_e, br_type_e, jump_e,
    input  rd_en_m, wr_en_m, mem_mode_m, csr_op_m, csr_en_m,
    input  rf_en_w, wb_sel_w, rd_w,
`ifdef CTRL_FORWARD_EN
    input  fwd_a_e, fwd_b_e,
`endif
    input  stall_f, stall_d, flush_d, flush_e, illegal_d
  );

  modport slave (
    input  instr_d, valid_d, br_taken_e,
    output aluop_e, sel_a_e, sel_b_e, br_type_e, jump_e,
    output rd_en_m, wr_en_m, mem_mode_m, csr_op_m, csr_en_m,
    output rf_en_w, wb_sel_w, rd_w,
`ifdef CTRL_FORWARD_EN
    output fwd_a_e, fwd_b_e,
`endif
    output stall_f, stall_d, flush_d, flush_e, illegal_d
  );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - RV32I+CSR control: decode, E/M/W control registers, hazard/flush logic.
// CTRL_FORWARD_EN adds forwarding selects; without it every RAW hazard on E/M stalls.
module pipe_ctrl #(
  parameter int         RF_ADDR_W = 5,
  parameter logic [2:0] NB_CODE   = 3'b010
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 f7b5;
  logic [RF_ADDR_W-1:0] rd_d, rs1_d, rs2_d;
  logic                 unused_instr;

  assign opcode       = bus.instr_d[6:0];
  assign funct3       = bus.instr_d[14:12];
  assign f7b5         = bus.instr_d[30];
  assign rd_d         = RF_ADDR_W'(bus.instr_d[11:7]);
  assign rs1_d        = RF_ADDR_W'(bus.instr_d[19:15]);
  assign rs2_d        = RF_ADDR_W'(bus.instr_d[24:20]);
  assign unused_instr = ^{bus.instr_d[31], bus.instr_d[29:25]};

  logic [3:0]           d_aluop;
  logic                 d_sel_a, d_sel_b, d_jump, d_rd_en, d_wr_en, d_csr_en, d_writes;
  logic [2:0]           d_br_type, d_mem_mode, d_csr_op;
  logic [1:0]           d_wb_sel;
  logic                 use_rs1, use_rs2, d_rf_en, legal;
  logic [RF_ADDR_W-1:0] d_rd;

  always_comb begin
    d_aluop    = 4'h0;
    d_sel_a    = 1'b0;
    d_sel_b    = 1'b0;
    d_br_type  = NB_CODE;
    d_jump     = 1'b0;
    d_rd_en    = 1'b0;
    d_wr_en    = 1'b0;
    d_mem_mode = 3'b000;
    d_csr_op   = 3'b000;
    d_csr_en   = 1'b0;
    d_writes   = 1'b0;
    d_wb_sel   = 2'd0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    if (bus.valid_d) begin
      case (opcode)
        OP_R: begin
          d_aluop  = {f7b5, funct3};
          d_writes = 1'b1;
          use_rs1  = 1'b1;
          use_rs2  = 1'b1;
        end
        OP_I: begin
          // only the shifts (funct3 = 001/101) carry funct7[5]; other immediates reuse that bit
          d_aluop  = (funct3[1:0] == 2'b01) ? {f7b5, funct3} : {1'b0, funct3};
          d_sel_b  = 1'b1;
          d_writes = 1'b1;
          use_rs1  = 1'b1;
        end
        OP_LOAD: begin
          d_sel_b    = 1'b1;
          d_rd_en    = 1'b1;
          d_mem_mode = funct3;
          d_writes   = 1'b1;
          d_wb_sel   = 2'd1;
          use_rs1    = 1'b1;
        end
        OP_JALR: begin
          d_sel_b  = 1'b1;
          d_jump   = 1'b1;
          d_writes = 1'b1;
          d_wb_sel = 2'd2;
          use_rs1  = 1'b1;
        end
        OP_STORE: begin
          d_sel_b    = 1'b1;
          d_wr_en    = 1'b1;
          d_mem_mode = funct3;
          use_rs1    = 1'b1;
          use_rs2    = 1'b1;
        end
        OP_BRANCH: begin
          d_sel_a   = 1'b1;
          d_sel_b   = 1'b1;
          d_br_type = funct3;
          use_rs1   = 1'b1;
          use_rs2   = 1'b1;
        end
        OP_LUI: begin
          d_aluop  = 4'b1111;
          d_sel_b  = 1'b1;
          d_writes = 1'b1;
        end
        OP_AUIPC: begin
          d_sel_a  = 1'b1;
          d_sel_b  = 1'b1;
          d_writes = 1'b1;
        end
        OP_JAL: begin
          d_sel_a  = 1'b1;
          d_sel_b  = 1'b1;
          d_jump   = 1'b1;
          d_writes = 1'b1;
          d_wb_sel = 2'd2;
        end
        OP_SYSTEM: begin
          // ECALL/EBREAK (funct3 = 0) have no pipeline effect here and decode as bubbles
          if (funct3 != 3'b000) begin
            d_csr_en = 1'b1;
            d_csr_op = funct3;
            d_writes = 1'b1;
            d_wb_sel = 2'd3;
            use_rs1  = ~funct3[2];
          end
        end
        default: ;
      endcase
    end
  end

  assign d_rf_en = d_writes & (rd_d != '0);
  assign d_rd    = d_writes ? rd_d : '0;
  assign legal   = opcode inside {OP_R, OP_I, OP_LOAD, OP_JALR, OP_STORE,
                                  OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM};

  logic [3:0]           e_aluop;
  logic                 e_sel_a, e_sel_b, e_jump, e_rd_en, e_wr_en, e_csr_en, e_rf_en;
  logic [2:0]           e_br_type, e_mem_mode, e_csr_op;
  logic [1:0]           e_wb_sel;
  logic [RF_ADDR_W-1:0] e_rd;
  logic                 m_rd_en, m_wr_en, m_csr_en, m_rf_en;
  logic [2:0]           m_mem_mode, m_csr_op;
  logic [1:0]           m_wb_sel;
  logic [RF_ADDR_W-1:0] m_rd;
  logic                 w_rf_en;
  logic [1:0]           w_wb_sel;
  logic [RF_ADDR_W-1:0] w_rd;

  logic ctrl_hz, load_use, data_hz, hit_e;

  assign hit_e    = (e_rd != '0) && ((use_rs1 && rs1_d == e_rd) || (use_rs2 && rs2_d == e_rd));
  assign ctrl_hz  = (bus.br_taken_e && e_br_type != NB_CODE) || e_jump;
  assign load_use = e_rd_en && hit_e;

`ifdef CTRL_FORWARD_EN
  logic [RF_ADDR_W-1:0] e_rs1, e_rs2;
  logic [1:0]           fwd_a, fwd_b;

  assign data_hz = load_use;

  always_comb begin
    fwd_a = 2'd0;
    fwd_b = 2'd0;
    if (m_rf_en && m_rd != '0 && m_rd == e_rs1)      fwd_a = 2'd1;
    else if (w_rf_en && w_rd != '0 && w_rd == e_rs1) fwd_a = 2'd2;
    if (m_rf_en && m_rd != '0 && m_rd == e_rs2)      fwd_b = 2'd1;
    else if (w_rf_en && w_rd != '0 && w_rd == e_rs2) fwd_b = 2'd2;
  end

  assign bus.fwd_a_e = fwd_a;
  assign bus.fwd_b_e = fwd_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_rs1 <= '0;
      e_rs2 <= '0;
    end else begin
      e_rs1 <= (bus.flush_e || !use_rs1) ? '0 : rs1_d;
      e_rs2 <= (bus.flush_e || !use_rs2) ? '0 : rs2_d;
    end
  end
`else
  logic hit_m;

  // write-first register file: a producer that has reached W needs no stall
  assign hit_m   = (m_rd != '0) && ((use_rs1 && rs1_d == m_rd) || (use_rs2 && rs2_d == m_rd));
  assign data_hz = load_use || (e_rf_en && hit_e) || (m_rf_en && hit_m);
`endif

  assign bus.stall_f   = data_hz && !ctrl_hz;
  assign bus.stall_d   = data_hz && !ctrl_hz;
  assign bus.flush_d   = ctrl_hz;
  assign bus.flush_e   = ctrl_hz || data_hz;
  assign bus.illegal_d = bus.valid_d && !legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_aluop    <= 4'h0;
      e_sel_a    <= 1'b0;
      e_sel_b    <= 1'b0;
      e_br_type  <= NB_CODE;
      e_jump     <= 1'b0;
      e_rd_en    <= 1'b0;
      e_wr_en    <= 1'b0;
      e_mem_mode <= 3'b000;
      e_csr_op   <= 3'b000;
      e_csr_en   <= 1'b0;
      e_rf_en    <= 1'b0;
      e_wb_sel   <= 2'd0;
      e_rd       <= '0;
      m_rd_en    <= 1'b0;
      m_wr_en    <= 1'b0;
      m_mem_mode <= 3'b000;
      m_csr_op   <= 3'b000;
      m_csr_en   <= 1'b0;
      m_rf_en    <= 1'b0;
      m_wb_sel   <= 2'd0;
      m_rd       <= '0;
      w_rf_en    <= 1'b0;
      w_wb_sel   <= 2'd0;
      w_rd       <= '0;
    end else begin
      if (bus.flush_e) begin
        e_aluop    <= 4'h0;
        e_sel_a    <= 1'b0;
        e_sel_b    <= 1'b0;
        e_br_type  <= NB_CODE;
        e_jump     <= 1'b0;
        e_rd_en    <= 1'b0;
        e_wr_en    <= 1'b0;
        e_mem_mode <= 3'b000;
        e_csr_op   <= 3'b000;
        e_csr_en   <= 1'b0;
        e_rf_en    <= 1'b0;
        e_wb_sel   <= 2'd0;
        e_rd       <= '0;
      end else begin
        e_aluop    <= d_aluop;
        e_sel_a    <= d_sel_a;
        e_sel_b    <= d_sel_b;
        e_br_type  <= d_br_type;
        e_jump     <= d_jump;
        e_rd_en    <= d_rd_en;
        e_wr_en    <= d_wr_en;
        e_mem_mode <= d_mem_mode;
        e_csr_op   <= d_csr_op;
        e_csr_en   <= d_csr_en;
        e_rf_en    <= d_rf_en;
        e_wb_sel   <= d_wb_sel;
        e_rd       <= d_rd;
      end
      m_rd_en    <= e_rd_en;
      m_wr_en    <= e_wr_en;
      m_mem_mode <= e_mem_mode;
      m_csr_op   <= e_csr_op;
      m_csr_en   <= e_csr_en;
      m_rf_en    <= e_rf_en;
      m_wb_sel   <= e_wb_sel;
      m_rd       <= e_rd;
      w_rf_en    <= m_rf_en;
      w_wb_sel   <= m_wb_sel;
      w_rd       <= m_rd;
    end
  end

  assign bus.aluop_e    = e_aluop;
  assign bus.sel_a_e    = e_sel_a;
  assign bus.sel_b_e    = e_sel_b;
  assign bus.br_type_e  = e_br_type;
  assign bus.jump_e     = e_jump;
  assign bus.rd_en_m    = m_rd_en;
  assign bus.wr_en_m    = m_wr_en;
  assign bus.mem_mode_m = m_mem_mode;
  assign bus.csr_op_m   = m_csr_op;
  assign bus.csr_en_m   = m_csr_en;
  assign bus.rf_en_w    = w_rf_en;
  assign bus.wb_sel_w   = w_wb_sel;
  assign bus.rd_w       = w_rd;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - Directed self-checking bench for pipe_ctrl (either CTRL_FORWARD_EN build).
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.RF_ADDR_W(5)) bus ();

  pipe_ctrl #(.RF_ADDR_W(5), .NB_CODE(3'b010)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // present one Decode-stage input for the next clock; checks follow at negedge+1
  task automatic step(input logic [31:0] i, input logic v, input logic t);
    @(negedge clk);
    bus.instr_d    = i;
    bus.valid_d    = v;
    bus.br_taken_e = t;
    #1;
  endtask

  function automatic logic [3:0] hz();
    return {bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e};
  endfunction

  function automatic logic [8:0] e_bundle();
    return {bus.aluop_e, bus.sel_a_e, bus.sel_b_e, bus.br_type_e, bus.jump_e};
  endfunction

  initial begin
    rst_n          = 1'b0;
    bus.instr_d    = 32'h0000_007F;
    bus.valid_d    = 1'b1;
    bus.br_taken_e = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_e_bundle", e_bundle(), {4'h0, 1'b0, 1'b0, 3'b010, 1'b0});
    chk("rst_m_w", {bus.rd_en_m, bus.wr_en_m, bus.csr_en_m, bus.rf_en_w, bus.rd_w}, 0);
    chk("rst_hz", hz(), 4'b0000);
    chk("rst_illegal_follows", bus.illegal_d, 1'b1);
    step(32'h0000_007F, 1'b0, 1'b0);
    chk("rst_illegal_invalid", bus.illegal_d, 1'b0);
    rst_n = 1'b1;

    step(32'h0, 1'b0, 1'b0);
    chk("post_rst_e", e_bundle(), {4'h0, 1'b0, 1'b0, 3'b010, 1'b0});
    chk("post_rst_m", {bus.rd_en_m, bus.wr_en_m, bus.mem_mode_m, bus.csr_op_m, bus.csr_en_m}, 0);
    chk("post_rst_w", {bus.rf_en_w, bus.wb_sel_w, bus.rd_w}, 0);
    chk("post_rst_hz", {hz(), bus.illegal_d}, 5'b00000);
`ifdef CTRL_FORWARD_EN
    chk("post_rst_fwd", {bus.fwd_a_e, bus.fwd_b_e}, 4'b0000);
`endif

    // add x3,x1,x2 ; srai x1,x2,3 ; addi x1,x0,-1 ; lui x7,0x12345
    step(32'h0020_81B3, 1'b1, 1'b0);
    chk("add_decode_hz", {hz(), bus.illegal_d}, 5'b00000);
    step(32'h4031_5093, 1'b1, 1'b0);
    chk("add_e", {bus.aluop_e, bus.sel_a_e, bus.sel_b_e}, {4'h0, 1'b0, 1'b0});
    step(32'hFFF0_0093, 1'b1, 1'b0);
    chk("srai_e", {bus.aluop_e, bus.sel_a_e, bus.sel_b_e}, {4'hD, 1'b0, 1'b1});
    chk("add_m", {bus.rd_en_m, bus.wr_en_m, bus.csr_en_m}, 3'b000);
    step(32'h1234_53B7, 1'b1, 1'b0);
    chk("addi_e", {bus.aluop_e, bus.sel_b_e}, {4'h0, 1'b1});
    chk("add_w", {bus.rf_en_w, bus.rd_w, bus.wb_sel_w}, {1'b1, 5'd3, 2'd0});
    step(32'h0, 1'b0, 1'b0);
    chk("lui_e", {bus.aluop_e, bus.sel_a_e, bus.sel_b_e}, {4'hF, 1'b0, 1'b1});
    chk("srai_w", {bus.rf_en_w, bus.rd_w}, {1'b1, 5'd1});
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("lui_w", {bus.rf_en_w, bus.rd_w, bus.wb_sel_w}, {1'b1, 5'd7, 2'd0});

    // lw x5,0(x1) then add x6,x5,x7
    step(32'h0000_A283, 1'b1, 1'b0);
    chk("lw_decode_hz", hz(), 4'b0000);
    step(32'h0072_8333, 1'b1, 1'b0);
    chk("load_use_hz", hz(), 4'b1101);
    chk("lw_e", {bus.aluop_e, bus.sel_b_e}, {4'h0, 1'b1});
    step(32'h0072_8333, 1'b1, 1'b0);
    chk("lw_m", {bus.rd_en_m, bus.wr_en_m, bus.mem_mode_m}, {1'b1, 1'b0, 3'b010});
    chk("flushed_e", e_bundle(), {4'h0, 1'b0, 1'b0, 3'b010, 1'b0});
`ifdef CTRL_FORWARD_EN
    chk("load_use_one_cycle", hz(), 4'b0000);
    step(32'h0, 1'b0, 1'b0);
    chk("fwd_from_w", {bus.fwd_a_e, bus.fwd_b_e}, {2'd2, 2'd0});
    chk("lw_w", {bus.rf_en_w, bus.wb_sel_w, bus.rd_w}, {1'b1, 2'd1, 5'd5});
    // addi x8,x0,1 then add x10,x8,x8: both operands from M
    step(32'h0010_0413, 1'b1, 1'b0);
    step(32'h0084_0533, 1'b1, 1'b0);
    chk("fwd_no_stall", hz(), 4'b0000);
    step(32'h0, 1'b0, 1'b0);
    chk("fwd_from_m", {bus.fwd_a_e, bus.fwd_b_e}, {2'd1, 2'd1});
`else
    chk("raw_m_stall", hz(), 4'b1101);
    step(32'h0072_8333, 1'b1, 1'b0);
    chk("raw_w_no_stall", hz(), 4'b0000);
    chk("lw_w", {bus.rf_en_w, bus.wb_sel_w, bus.rd_w}, {1'b1, 2'd1, 5'd5});
    step(32'h0, 1'b0, 1'b0);
    chk("add_after_stall_e", {bus.aluop_e, bus.sel_b_e}, {4'h0, 1'b0});
`endif
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);

    // addi x8,x0,1 ; beq x0,x0,+8 ; add x9,x8,x0 (branch resolves while add waits on x8)
    step(32'h0010_0413, 1'b1, 1'b1);
    chk("taken_no_branch", hz(), 4'b0000);
    step(32'h0000_0463, 1'b1, 1'b0);
    chk("beq_decode_hz", hz(), 4'b0000);
    step(32'h0004_04B3, 1'b1, 1'b0);
    chk("beq_e_type", bus.br_type_e, 3'b000);
`ifdef CTRL_FORWARD_EN
    chk("beq_not_taken", hz(), 4'b0000);
`else
    chk("beq_not_taken", hz(), 4'b1101);
`endif
    bus.br_taken_e = 1'b1;
    #1;
    chk("beq_taken_override", hz(), 4'b0011);
    step(32'h0, 1'b0, 1'b0);
    chk("after_flush_e", e_bundle(), {4'h0, 1'b0, 1'b0, 3'b010, 1'b0});

    // jal x1
    step(32'h0000_00EF, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("jal_e", {bus.jump_e, bus.sel_a_e, bus.sel_b_e, bus.aluop_e}, {3'b111, 4'h0});
    chk("jal_flush", hz(), 4'b0011);
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("jal_w", {bus.rf_en_w, bus.wb_sel_w, bus.rd_w}, {1'b1, 2'd2, 5'd1});

    // csrrw x4,mstatus,x9
    step(32'h3004_9273, 1'b1, 1'b0);
    chk("csr_decode", {hz(), bus.illegal_d}, 5'b00000);
    step(32'h0, 1'b0, 1'b0);
    chk("csr_e", {bus.aluop_e, bus.br_type_e, bus.jump_e}, {4'h0, 3'b010, 1'b0});
    step(32'h0, 1'b0, 1'b0);
    chk("csr_m", {bus.csr_en_m, bus.csr_op_m, bus.rd_en_m, bus.wr_en_m}, {1'b1, 3'b001, 2'b00});
    step(32'h0, 1'b0, 1'b0);
    chk("csr_w", {bus.rf_en_w, bus.wb_sel_w, bus.rd_w}, {1'b1, 2'd3, 5'd4});

    // add x0,x1,x2 must not write
    step(32'h0020_8033, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("rd0_no_write", bus.rf_en_w, 1'b0);

    step(32'h0000_0073, 1'b1, 1'b0);
    chk("ecall_legal", bus.illegal_d, 1'b0);

    // opcode 7F shaped like add x3,x1,x2
    step(32'h0020_81FF, 1'b1, 1'b0);
    chk("illegal_flag", {bus.illegal_d, hz()}, 5'b10000);
    step(32'h0, 1'b0, 1'b0);
    chk("illegal_bubble_e", e_bundle(), {4'h0, 1'b0, 1'b0, 3'b010, 1'b0});
    chk("illegal_clears", bus.illegal_d, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("illegal_bubble_w", {bus.rf_en_w, bus.rd_w, bus.wb_sel_w}, 0);

    // mid-stream reset discards in-flight control
    step(32'h4031_5093, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("pre_reset_e", bus.aluop_e, 4'hD);
    rst_n = 1'b0;
    #1;
    chk("async_reset_e", e_bundle(), {4'h0, 1'b0, 1'b0, 3'b010, 1'b0});
    step(32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(32'h1234_53B7, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("post_reset_lui_e", {bus.aluop_e, bus.sel_b_e}, {4'hF, 1'b1});
    chk("post_reset_w", {bus.rf_en_w, bus.rd_w}, 0);
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("post_reset_lui_w", {bus.rf_en_w, bus.rd_w}, {1'b1, 5'd7});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
